fre_gen: RTL and testbench

Programmable square-wave generator driven by a phase accumulator (NCO) on `sys_clk`; it produces `clk_out` at f = FTW · CLK_FS / 2^ACC_W with a programmable duty threshold. It is the stimulus counterpart of the frequency meter: it produces known frequencies that the meter measures, for self-test and for driving external loads. Configuration is accepted over a valid/ready handshake and is applied only at period boundaries, so the output never glitches.

---
 rtl/fre_gen_pkg.sv | 14 +
 rtl/fre_gen_phase.sv | 40 ++++
 rtl/fre_gen.sv | 204 ++++++++++++++++++++
 tb/tb_fre_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fre_gen_pkg.sv
// fre_gen shared types and default widths.
// Imported by the phase core and the top level.
package fre_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int ACC_W_DEF   = 32;
  localparam int BURST_W_DEF = 16;

endpackage

// File: rtl/fre_gen_phase.sv
// fre_gen phase core: accumulator, carry-out adder
// and duty comparator on the next phase value.
module fre_gen_phase
  import fre_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] ftw,
  input  logic [ACC_W-1:0] duty,
  output logic             phase_out,
  output logic             wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // one extra bit so the carry marks a period wrap
  always_comb begin
    sum = {1'b0, acc} + {1'b0, ftw};
  end

  assign wrap      = en & sum[ACC_W];
  assign phase_out = (sum[ACC_W-1:0] < duty);

  // clear wins so a stopping edge parks at zero
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/fre_gen.sv
// fre_gen: NCO square-wave generator, glitch-free reconfig.
// Optional burst mode under FRE_GEN_BURST_EN.
module fre_gen
  import fre_gen_pkg::*;
#(
  parameter int          ACC_W   = ACC_W_DEF,
`ifdef FRE_GEN_BURST_EN
  parameter int          BURST_W = BURST_W_DEF,
`endif
  parameter logic [63:0] CLK_FS  = 64'd200_000_000
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [ACC_W-1:0]   cfg_duty,
`ifdef FRE_GEN_BURST_EN
  input  logic [BURST_W-1:0] cfg_burst_len,
  output logic               burst_done,
`endif
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               period_tick,
  output logic               busy
);

  if (CLK_FS == 64'd0) begin : g_fs_chk
    $error("fre_gen: CLK_FS must be non-zero");
  end

  state_t state;
  state_t state_nx;

  logic [ACC_W-1:0] ftw_a;
  logic [ACC_W-1:0] duty_a;
  logic [ACC_W-1:0] ftw_s;
  logic [ACC_W-1:0] duty_s;
  logic             pend;
  logic             accept;
  logic             apply;
  logic             go_idle;
  logic             burst_end;
  logic             ph_en;
  logic             ph_clr;
  logic             ph_out;
  logic             wrap;

  assign cfg_ready = (state == IDLE) | ~pend;
  assign accept    = cfg_valid & cfg_ready;
  assign apply     = pend & (wrap | go_idle);

  fre_gen_phase #(
    .ACC_W(ACC_W)
  ) u_phase (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .en       (ph_en),
    .clr      (ph_clr),
    .ftw      (ftw_a),
    .duty     (duty_a),
    .phase_out(ph_out),
    .wrap     (wrap)
  );

  // state register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state; zero ftw never wraps, so stop exits at once
  always_comb begin
    state_nx = state;
    go_idle  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (burst_end || (stop && ftw_a == '0)) begin
          go_idle = 1'b1;
        end else if (stop) begin
          state_nx = STOPPING;
        end
      end
      STOPPING: begin
        if (wrap || ftw_a == '0) begin
          go_idle = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (go_idle) begin
      state_nx = IDLE;
    end
  end

  // FSM outputs driving the phase core
  always_comb begin
    ph_en  = (state != IDLE);
    ph_clr = (state == IDLE) | go_idle;
    busy   = (state != IDLE);
  end

  // registered square wave and wrap pulse
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (state == IDLE) begin
        clk_out <= start & (duty_a != '0);
      end else if (go_idle) begin
        clk_out <= 1'b0;
      end else begin
        clk_out <= ph_out;
      end
    end
  end

  // active/shadow config; shadow lands only on a wrap
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ftw_a  <= '0;
      duty_a <= '0;
      ftw_s  <= '0;
      duty_s <= '0;
      pend   <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        ftw_a  <= cfg_ftw;
        duty_a <= cfg_duty;
      end
    end else begin
      if (apply) begin
        ftw_a  <= ftw_s;
        duty_a <= duty_s;
        pend   <= 1'b0;
      end
      if (accept) begin
        ftw_s  <= cfg_ftw;
        duty_s <= cfg_duty;
        pend   <= 1'b1;
      end
    end
  end

`ifdef FRE_GEN_BURST_EN
  logic [BURST_W-1:0] blen_a;
  logic [BURST_W-1:0] blen_s;
  logic [BURST_W-1:0] bcnt;

  assign burst_end = (state == RUN) & wrap
                   & (blen_a != '0)
                   & (bcnt + 1'b1 == blen_a);

  // burst length follows the same active/shadow path
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      blen_a <= '0;
      blen_s <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        blen_a <= cfg_burst_len;
      end
    end else begin
      if (apply) begin
        blen_a <= blen_s;
      end
      if (accept) begin
        blen_s <= cfg_burst_len;
      end
    end
  end

  // wrap counter and completion pulse
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bcnt       <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_end;
      if (state == IDLE && start) begin
        bcnt <= '0;
      end else if (wrap) begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end
`else
  assign burst_end = 1'b0;
`endif

endmodule

// File: tb/tb_fre_gen.sv
// fre_gen bench: directed and random steps vs a
// phase-arithmetic reference model, ACC_W = 8.
module tb_fre_gen;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic         sys_clk   = 1'b0;
  logic         rst       = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_ftw   = '0;
  logic [W-1:0] cfg_duty  = '0;
  logic         start     = 1'b0;
  logic         stop      = 1'b0;
  logic         clk_out;
  logic         period_tick;
  logic         busy;
`ifdef FRE_GEN_BURST_EN
  logic [15:0]  cfg_burst_len = '0;
  logic         burst_done;
`endif

  int n_err = 0;
  int n_chk = 0;

  int m_ph, m_ftw, m_duty, m_ftw_s, m_duty_s;
  int m_cnt, m_blen, m_blen_s;
  bit m_run, m_stopping, m_pend;
  bit e_clk, e_tick, e_done;

  fre_gen #(
    .ACC_W(W)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ftw      (cfg_ftw),
    .cfg_duty     (cfg_duty),
`ifdef FRE_GEN_BURST_EN
    .cfg_burst_len(cfg_burst_len),
    .burst_done   (burst_done),
`endif
    .start        (start),
    .stop         (stop),
    .clk_out      (clk_out),
    .period_tick  (period_tick),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_ftw = 0; m_duty = 0;
    m_ftw_s = 0; m_duty_s = 0;
    m_cnt = 0; m_blen = 0; m_blen_s = 0;
    m_run = 0; m_stopping = 0; m_pend = 0;
    e_clk = 0; e_tick = 0; e_done = 0;
  endtask

  task automatic model_edge();
    bit rdy, take, w, fin, done;
    int s;
    int blen_in;
    blen_in = 0;
`ifdef FRE_GEN_BURST_EN
    blen_in = int'(cfg_burst_len);
`endif
    rdy  = !m_run || !m_pend;
    take = cfg_valid && rdy;
    e_done = 0;
    if (!m_run) begin
      e_tick = 0;
      e_clk  = start && (m_duty != 0);
      if (start) begin
        m_run = 1; m_stopping = 0;
        m_ph = 0; m_cnt = 0;
      end
      if (take) begin
        m_ftw  = int'(cfg_ftw);
        m_duty = int'(cfg_duty);
        m_blen = blen_in;
      end
    end else begin
      s = m_ph + m_ftw;
      w = (s >= MOD);
      m_ph = s % MOD;
      e_tick = w;
      e_clk  = (m_ph < m_duty);
      done = 0;
`ifdef FRE_GEN_BURST_EN
      if (w) m_cnt++;
      done = !m_stopping && w && m_blen != 0
             && m_cnt == m_blen;
`endif
      fin = done
          || (m_stopping && (w || m_ftw == 0))
          || (!m_stopping && stop && m_ftw == 0);
      if (!m_stopping && stop) m_stopping = 1;
      if (m_pend && (w || fin)) begin
        m_ftw = m_ftw_s; m_duty = m_duty_s;
        m_blen = m_blen_s; m_pend = 0;
      end
      if (take) begin
        m_ftw_s  = int'(cfg_ftw);
        m_duty_s = int'(cfg_duty);
        m_blen_s = blen_in;
        m_pend = 1;
      end
      if (fin) begin
        m_run = 0; m_stopping = 0;
        m_ph = 0; e_clk = 0;
      end
      e_done = done;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
    check({tag, ".tick"}, 32'(period_tick), 32'(e_tick));
    check({tag, ".busy"}, 32'(busy), 32'(m_run));
    check({tag, ".ready"}, 32'(cfg_ready),
          32'(!m_run || !m_pend));
`ifdef FRE_GEN_BURST_EN
    check({tag, ".done"}, 32'(burst_done), 32'(e_done));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cfg(input int ftw, input int duty,
                     input int blen);
    cfg_valid = 1'b1;
    cfg_ftw   = W'(ftw);
    cfg_duty  = W'(duty);
`ifdef FRE_GEN_BURST_EN
    cfg_burst_len = 16'(blen);
`else
    if (blen != 0) cfg_valid = 1'b1;
`endif
    tick("cfg");
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #10 rst = 1'b1;

    // ftw=64 duty=128: 1,1,0,0 repeating
    cfg(64, 128, 0);
    start = 1'b1;
    tick("start64");
    start = 1'b0;
    check("start.clk_high", 32'(clk_out), 32'd1);
    repeat (11) tick("run64");

    // reconfigure mid-run, applies at next wrap
    tick("pre_load");
    cfg(32, 128, 0);
    check("load.ready_low", 32'(cfg_ready), 32'd0);
    repeat (20) tick("run32");

    // stop mid-period then drain to IDLE
    repeat (3) tick("mid");
    stop = 1'b1;
    tick("stop");
    stop = 1'b0;
    repeat (10) tick("drain");
    check("drain.idle", 32'(busy), 32'd0);
    stop = 1'b1;
    tick("stop_idle");
    stop = 1'b0;
    tick("idle");

    // start+stop together, duty 0 stays low
    cfg(64, 0, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick("start_stop");
    start = 1'b0;
    stop  = 1'b0;
    check("ss.busy", 32'(busy), 32'd1);
    repeat (10) tick("duty0");
    stop = 1'b1;
    tick("stop0");
    stop = 1'b0;
    repeat (6) tick("drain0");

    // async reset mid-run
    cfg(64, 128, 0);
    start = 1'b1;
    tick("start_r");
    start = 1'b0;
    repeat (5) tick("run_r");
    cfg(16, 40, 0);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #2 rst = 1'b1;
    tick("post_rst");

`ifdef FRE_GEN_BURST_EN
    // three-period burst then continuous
    cfg(64, 128, 3);
    start = 1'b1;
    tick("b_start");
    start = 1'b0;
    repeat (16) tick("burst3");
    check("burst3.idle", 32'(busy), 32'd0);
    cfg(64, 128, 0);
    start = 1'b1;
    tick("b0_start");
    start = 1'b0;
    repeat (20) tick("burst0");
    check("burst0.busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick("b0_stop");
    stop = 1'b0;
    repeat (6) tick("b0_drain");
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ftw   = ($urandom_range(0, 9) == 0) ? W'(0)
                : W'($urandom_range(1, 80));
      cfg_duty  = W'($urandom_range(0, 255));
`ifdef FRE_GEN_BURST_EN
      cfg_burst_len = 16'($urandom_range(0, 4));
`endif
      start = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick("final");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
